// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: sequential instruction fetch into a DEPTH-entry prefetch FIFO with redirect and halt.
module inst_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [4:0]  level
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [31:0]   fetch_pc;
    logic [PW-1:0] head, tail;
    logic [31:0]   mem_pc   [DEPTH];
    logic [31:0]   mem_inst [DEPTH];
    logic          pop, push;
    assign imem_addr = fetch_pc;
    assign out_valid = level != 5'd0;
    assign out_inst  = out_valid ? mem_inst[head] : 32'd0;
    assign out_pc    = out_valid ? mem_pc[head] : 32'd0;
    assign pop       = out_valid & out_ready & ~redirect_valid;
    assign push      = ~redirect_valid & ~halt & ((level < 5'(DEPTH)) | pop);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            level    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            head     <= '0;
            tail     <= '0;
            level    <= '0;
        end else begin
            fetch_pc <= push ? fetch_pc + 32'd1 : fetch_pc;
            tail     <= push ? tail + PW'(1) : tail;
            head     <= pop ? head + PW'(1) : head;
            level    <= level + 5'(push) - 5'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[tail]   <= fetch_pc;
            mem_inst[tail] <= imem_data;
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: random and directed stimulus checked against a queue-based fetch model.
module tb_inst_fetch_unit;
    localparam int DEPTH = 4;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr, imem_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_inst, out_pc;
    logic [4:0]  level;
    int          total = 0, bad = 0;
    logic [31:0] q[$];
    logic [31:0] mpc = 32'd0;

    inst_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .level(level)
    );

    always #5 clk = ~clk;
    assign imem_data = 32'hA0 + imem_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int n = q.size();
        chk("out_valid", 32'(out_valid), 32'(n != 0));
        chk("level", 32'(level), 32'(n));
        chk("imem_addr", imem_addr, mpc);
        chk("out_pc", out_pc, n != 0 ? q[0] : 32'd0);
        chk("out_inst", out_inst, n != 0 ? 32'hA0 + q[0] : 32'd0);
    endtask

    // Called at a falling edge: check, drive, model the rising edge, return at the next falling edge.
    task automatic step(input logic r, input logic rv, input logic [31:0] rp, input logic h);
        logic p, w;
        check_all();
        out_ready = r; redirect_valid = rv; redirect_pc = rp; halt = h;
        @(posedge clk);
        p = q.size() != 0 && r && !rv;
        w = !rv && !h && (q.size() < DEPTH || p);
        if (rv) begin
            q.delete();
            mpc = rp;
        end else begin
            if (p) void'(q.pop_front());
            if (w) begin
                q.push_back(mpc);
                mpc = mpc + 32'd1;
            end
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        out_ready = 1'b1; redirect_valid = 1'b0; halt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        q.delete();
        mpc = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        chk("sat_level", 32'(level), 32'(DEPTH));
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 32'h100, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        step(1, 1, 32'h200, 0);
        step(1, 1, 32'h300, 1);
        step(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        step(1, 1, 32'hFFFF_FFFE, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        step(1, 1, 32'h3FF, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        pulse_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0, $urandom, $urandom_range(7, 0) == 0);
        check_all();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 SHALL provide parameter: DEPTH, 4, prefetch buffer entries (power of two, 2..16).
REQ-002 SHALL provide parameter: RESET_PC, 32'd0, word address fetched first after reset.
REQ-003 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: imem_addr  output  32  word address driven to the instruction memory read port.
REQ-006 SHALL have port: imem_data  input  32  instruction word returned combinationally for imem_addr in the same cycle.
REQ-007 SHALL have port: redirect_valid  input  1  branch/jump redirect request.
REQ-008 SHALL have port: redirect_pc  input  32  new word address, sampled when redirect_valid=1.
REQ-009 SHALL have port: halt  input  1  suspends new fetches while high.
REQ-010 SHALL have port: out_valid  output  1  head entry available to decode.
REQ-011 SHALL have port: out_ready  input  1  decode accepts head entry.
REQ-012 SHALL have port: out_inst  output  32  instruction word of head entry.
REQ-013 SHALL have port: out_pc  output  32  word address of head entry.
REQ-014 SHALL have port: level  output  5  current buffer occupancy, 0..DEPTH.

Function
REQ-015 SHALL hold a 32-bit fetch_pc register; imem_addr SHALL equal fetch_pc combinationally.
REQ-016 SHALL define pop = out_valid & out_ready & ~redirect_valid.
REQ-017 SHALL define push = ~redirect_valid & ~halt & ((level < DEPTH) | pop).
REQ-018 On push, SHALL write {fetch_pc, imem_data} at tail and increment fetch_pc by 1, wrapping modulo 2^32.
REQ-019 On pop, SHALL advance head; out_inst/out_pc SHALL then present the next entry.
REQ-020 Push and pop in the same cycle SHALL leave level unchanged, including when level = DEPTH.
REQ-021 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-022 out_valid SHALL equal (level != 0); out_inst and out_pc SHALL be 0 when level = 0.
REQ-023 Latency: an instruction pushed in cycle N SHALL be presented with out_valid=1 in cycle N+1 if the buffer was empty.
REQ-024 Redirect SHALL have priority over all other events: level forced to 0, head = tail = 0, fetch_pc <= redirect_pc, no push, handshake in that cycle discarded.
REQ-025 The first fetch from redirect_pc SHALL occur in the cycle after redirect_valid, subject to halt.
REQ-026 halt=1 SHALL freeze fetch_pc and block push; pops SHALL continue so the buffer drains.
REQ-027 redirect_valid and halt together SHALL apply the redirect; fetching SHALL resume only once halt=0.
REQ-028 With level = DEPTH and no pop, fetch_pc and buffer contents SHALL hold unchanged.
REQ-029 out_inst/out_pc SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for clk, set fetch_pc=RESET_PC, level=0, head=tail=0, out_valid=0, out_inst=0, out_pc=0.
REQ-031 Reset asserted mid-operation SHALL discard all buffered entries; no partial entry SHALL survive.
REQ-032 The first push SHALL occur on the first rising clk edge with rst_n=1.

Verification
REQ-033 Reset release, out_ready=1, imem returns 0xA0+addr -> out_valid=1 from cycle 1, out_pc 0,1,2,... one per cycle, out_inst 0xA0,0xA1,...
REQ-034 out_ready=0 for 10 cycles -> level saturates at 4, imem_addr holds at 4, out_pc stays 0; then out_ready=1 -> pcs 0..7 in order, no gaps or duplicates.
REQ-035 Redirect to 0x100 with level=3 -> next cycle level=0, out_valid=0; following cycle out_pc=0x100, imem_addr=0x101.
REQ-036 halt=1 with level=2 and out_ready=1 -> two pops (level 2->1->0), imem_addr frozen; halt=0 -> fetch resumes at the frozen address.
REQ-037 Redirect in the same cycle as an accepted handshake at level=DEPTH -> popped entry discarded, level=0 next cycle, fetch_pc=redirect_pc.
REQ-038 rst_n pulsed low mid-stream with fetch_pc=0x3FF -> out_valid=0 and imem_addr=0 before the next clk edge; after release, stream restarts at pc 0.
